// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and helpers for the CDC handshake arbiter family.
//   arb_state_t      - arbiter FSM encoding (IDLE=0, ISSUE=1, ARMED=2, WAIT=3)
//   id_width()       - source-ID tag width for a given requester count (min 1)
//   TIMEOUT_CYC_DEF  - default busy-stall limit
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_ARMED = 2'd2,
      S_WAIT  = 2'd3
   } arb_state_t;

   localparam int unsigned TIMEOUT_CYC_DEF = 1024;

   // clog2 with a floor of one bit so a 2-requester build still has a tag
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// cdc_rr_pick: combinational rotate-priority picker.
// Returns the first set request at or after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req      in  NUM_REQ  request vector
//   ptr      in  ID_W     search start index
//   idx_c    out ID_W     winner index (0 when nothing found)
//   found_c  out 1        at least one request set
module cdc_rr_pick
   import cdc_hs_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    idx_c,
   output logic               found_c
);

   logic [ID_W-1:0] k;

   // linear scan from ptr; first hit wins
   always_comb begin
      idx_c   = '0;
      found_c = 1'b0;
      k       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = ID_W'((32'(ptr) + i) % NUM_REQ);
         if (!found_c && req[k]) begin
            found_c = 1'b1;
            idx_c   = k;
         end
      end
   end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: round-robin scheduler sharing one 2-phase CDC handshake
// channel among NUM_REQ requesters, in the source clock domain.
// Optional feature macro: CDC_ARB_TIMEOUT_EN (sticky busy-stall flag).
// Ports:
//   i_clk        in  1               source clock
//   i_rst        in  1               async active-high reset
//   i_req_valid  in  NUM_REQ         per-requester request
//   i_req_data   in  NUM_REQ*DATA_W  flattened payloads, req k at [k*DATA_W +: DATA_W]
//   o_req_ready  out NUM_REQ         one-hot single-cycle accept pulse
//   o_cdc_valid  out 1               single-cycle launch strobe
//   o_cdc_data   out ID_W+DATA_W     {winner ID, payload}, held until next launch
//   i_cdc_busy   in  1               channel busy
//   o_active     out 1               FSM not idle
//   o_grant_id   out ID_W            current/last winner
//   o_timeout    out 1               sticky stall flag (0 unless CDC_ARB_TIMEOUT_EN)
module cdc_hs_arbiter
   import cdc_hs_pkg::*;
#(
   parameter  int unsigned NUM_REQ     = 4,
   parameter  int unsigned DATA_W      = 8,
   parameter  int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   localparam int unsigned ID_W        = id_width(NUM_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic                      o_cdc_valid,
   output logic [ID_W+DATA_W-1:0]    o_cdc_data,
   input  logic                      i_cdc_busy,
   output logic                      o_active,
   output logic [ID_W-1:0]           o_grant_id,
   output logic                      o_timeout
);

   arb_state_t        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win_c;
   logic              found_c;
   logic [DATA_W-1:0] data_sel_c;

   cdc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (i_req_valid),
      .ptr     (rr_ptr),
      .idx_c   (win_c),
      .found_c (found_c)
   );

   // payload mux for the candidate winner
   always_comb begin
      data_sel_c = i_req_data[32'(win_c)*DATA_W +: DATA_W];
   end

   // arbiter FSM; ready/valid are set on the IDLE->ISSUE edge so they are
   // visible exactly during the ISSUE cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         o_req_ready <= '0;
         o_cdc_valid <= 1'b0;
         o_cdc_data  <= '0;
         o_grant_id  <= '0;
         o_active    <= 1'b0;
      end else begin
         o_req_ready <= '0;
         o_cdc_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found_c && !i_cdc_busy) begin
                  o_cdc_data  <= {win_c, data_sel_c};
                  o_grant_id  <= win_c;
                  o_req_ready <= NUM_REQ'(1) << win_c;
                  o_cdc_valid <= 1'b1;
                  o_active    <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rr_ptr <= (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + ID_W'(1);
               state  <= S_ARMED;
            end
            // ignore a busy that has not yet risen for this launch
            S_ARMED: begin
               if (i_cdc_busy) state <= S_WAIT;
            end
            S_WAIT: begin
               if (!i_cdc_busy) begin
                  o_active <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CDC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] stall_cnt;

   // saturating stall counter; flag sets on the edge the count hits the limit
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt <= '0;
         o_timeout <= 1'b0;
      end else if (state == S_ISSUE) begin
         stall_cnt <= '0;
      end else if (state == S_ARMED || state == S_WAIT) begin
         if (stall_cnt != CNT_W'(TIMEOUT_CYC)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (stall_cnt == CNT_W'(TIMEOUT_CYC - 1)) o_timeout <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^(32'(TIMEOUT_CYC));
   assign o_timeout          = 1'b0;
`endif

endmodule
